// File: rtl/compl_mul.sv
// rtl/compl_mul.sv - fully pipelined signed complex multiplier, 3 register stages
// Full-precision (a_i + j*a_q) * (b_i + j*b_q); one result per clock, no handshake.
module compl_mul #(
  parameter  int DATA_W = 18,
  localparam int OUT_W  = 2*DATA_W+1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_a_i_i,
  input  logic [DATA_W-1:0] data_a_q_i,
  input  logic [DATA_W-1:0] data_b_i_i,
  input  logic [DATA_W-1:0] data_b_q_i,
  output logic [OUT_W-1:0]  data_i_o,
  output logic [OUT_W-1:0]  data_q_o
);

  localparam int PROD_W = 2*DATA_W;

  logic signed [DATA_W-1:0] a_i_r, a_q_r, b_i_r, b_q_r;
  logic signed [PROD_W-1:0] p_ii, p_qq, p_iq, p_qi;
  logic signed [OUT_W-1:0]  p_ii_x, p_qq_x, p_iq_x, p_qi_x;
  logic signed [OUT_W-1:0]  res_i, res_q;

  // One extra bit of headroom makes the sum/difference exact for every operand pair.
  assign p_ii_x = $signed({p_ii[PROD_W-1], p_ii});
  assign p_qq_x = $signed({p_qq[PROD_W-1], p_qq});
  assign p_iq_x = $signed({p_iq[PROD_W-1], p_iq});
  assign p_qi_x = $signed({p_qi[PROD_W-1], p_qi});

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      a_i_r <= '0;
      a_q_r <= '0;
      b_i_r <= '0;
      b_q_r <= '0;
      p_ii  <= '0;
      p_qq  <= '0;
      p_iq  <= '0;
      p_qi  <= '0;
      res_i <= '0;
      res_q <= '0;
    end else begin
      a_i_r <= $signed(data_a_i_i);
      a_q_r <= $signed(data_a_q_i);
      b_i_r <= $signed(data_b_i_i);
      b_q_r <= $signed(data_b_q_i);
      p_ii  <= a_i_r * b_i_r;
      p_qq  <= a_q_r * b_q_r;
      p_iq  <= a_i_r * b_q_r;
      p_qi  <= a_q_r * b_i_r;
      res_i <= p_ii_x - p_qq_x;
      res_q <= p_iq_x + p_qi_x;
    end
  end

  assign data_i_o = res_i;
  assign data_q_o = res_q;

endmodule

// File: tb/tb_compl_mul.sv
// tb/tb_compl_mul.sv - directed self-checking bench for compl_mul
// Hand-computed vectors plus a 3-deep reference delay line for streaming.
module tb_compl_mul;

  logic               clk = 1'b0;
  logic               srst = 1'b1;
  logic signed [17:0] a_i = '0, a_q = '0, b_i = '0, b_q = '0;
  logic signed [36:0] out_i, out_q;

  int checks = 0;
  int failures = 0;

  compl_mul dut (
    .clk_i      (clk),
    .srst_i     (srst),
    .data_a_i_i (a_i),
    .data_a_q_i (a_q),
    .data_b_i_i (b_i),
    .data_b_q_i (b_q),
    .data_i_o   (out_i),
    .data_q_o   (out_q)
  );

  always #5 clk = ~clk;

  longint vai [5] = '{1, 1, 2, 131071, -131072};
  longint vaq [5] = '{0, 1, -3, -131072, -131072};
  longint vbi [5] = '{1, 1, 4, 65536, -131072};
  longint vbq [5] = '{0, 1, 5, -32768, -131072};
  longint ei  [5] = '{1, 0, 23, 64'sd4294901760, 0};
  longint eq  [5] = '{0, 2, -2, -64'sd12884869120, 64'sd34359738368};

  longint rai = 12345, raq = -6789, rbi = -2468, rbq = 1357;
  longint rei = -21254787, req = 33507417;

  task automatic set_in(input longint ai, input longint aq, input longint bi, input longint bq);
    a_i = 18'(ai);
    a_q = 18'(aq);
    b_i = 18'(bi);
    b_q = 18'(bq);
  endtask

  task automatic wait3();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic signed [63:0] z;
    z = 0;
    #1;
    checks++;
    if (out_i !== z || out_q !== z) begin
      failures++;
      $display("FAIL reset_init: got (%0d,%0d) want (0,0)", out_i, out_q);
    end
    @(negedge clk);
    srst = 1'b0;
    set_in(vai[2], vaq[2], vbi[2], vbq[2]);
    wait3();
    checks++;
    if (out_i !== 37'sd23) begin
      failures++;
      $display("FAIL reset_prefill: got %0d want 23", out_i);
    end
    #2 srst = 1'b1;
    #1;
    checks++;
    if (out_i !== z || out_q !== z) begin
      failures++;
      $display("FAIL reset_async: got (%0d,%0d) want (0,0)", out_i, out_q);
    end
    @(posedge clk); #1;
    checks++;
    if (out_i !== z || out_q !== z) begin
      failures++;
      $display("FAIL reset_held: got (%0d,%0d) want (0,0)", out_i, out_q);
    end
    set_in(0, 0, 0, 0);
    @(negedge clk);
    srst = 1'b0;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      checks++;
      if (out_i !== z || out_q !== z) begin
        failures++;
        $display("FAIL reset_release_edge%0d: got (%0d,%0d) want (0,0)", e, out_i, out_q);
      end
    end
  endtask

  task automatic test_vec(input string name, input int k);
    logic signed [63:0] xi, xq;
    xi = ei[k];
    xq = eq[k];
    set_in(vai[k], vaq[k], vbi[k], vbq[k]);
    wait3();
    checks++;
    if (out_i !== xi || out_q !== xq) begin
      failures++;
      $display("FAIL %s: got (%0d,%0d) want (%0d,%0d)", name, out_i, out_q, xi, xq);
    end
  endtask

  task automatic test_basic();
    test_vec("basic_1x1", 0);
    test_vec("basic_1p1j_sq", 1);
  endtask

  task automatic test_sign();
    test_vec("sign", 2);
  endtask

  task automatic test_extremes();
    test_vec("extreme_mixed", 3);
    test_vec("extreme_min", 4);
  endtask

  task automatic test_random();
    logic signed [63:0] xi, xq;
    xi = rei;
    xq = req;
    set_in(rai, raq, rbi, rbq);
    wait3();
    checks++;
    if (out_i !== xi || out_q !== xq) begin
      failures++;
      $display("FAIL random: got (%0d,%0d) want (%0d,%0d)", out_i, out_q, xi, xq);
    end
  endtask

  task automatic test_reset_release();
    logic signed [63:0] z, xi, xq;
    z = 0;
    xi = ei[3];
    xq = eq[3];
    @(negedge clk);
    srst = 1'b1;
    set_in(vai[3], vaq[3], vbi[3], vbq[3]);
    @(negedge clk);
    srst = 1'b0;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      checks++;
      if (out_i !== z || out_q !== z) begin
        failures++;
        $display("FAIL release_zero_edge%0d: got (%0d,%0d) want (0,0)", e, out_i, out_q);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_i !== xi || out_q !== xq) begin
      failures++;
      $display("FAIL release_first: got (%0d,%0d) want (%0d,%0d)", out_i, out_q, xi, xq);
    end
  endtask

  task automatic test_back_to_back();
    longint sai [8], saq [8], sbi [8], sbq [8], fi [8], fq [8];
    logic signed [63:0] pi [3], pq [3];
    for (int k = 0; k < 8; k++) begin
      sai[k] = 0; saq[k] = 0; sbi[k] = 0; sbq[k] = 0; fi[k] = 0; fq[k] = 0;
    end
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        sai[k] = vai[k + 1]; saq[k] = vaq[k + 1]; sbi[k] = vbi[k + 1]; sbq[k] = vbq[k + 1];
        fi[k] = ei[k + 1]; fq[k] = eq[k + 1];
      end else begin
        sai[k] = rai; saq[k] = raq; sbi[k] = rbi; sbq[k] = rbq;
        fi[k] = rei; fq[k] = req;
      end
    end
    @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      pi[d] = 0;
      pq[d] = 0;
    end
    for (int c = 0; c < 8; c++) begin
      set_in(sai[c], saq[c], sbi[c], sbq[c]);
      @(posedge clk);
      pi[2] = pi[1]; pq[2] = pq[1];
      pi[1] = pi[0]; pq[1] = pq[0];
      pi[0] = sai[c] * sbi[c] - saq[c] * sbq[c];
      pq[0] = sai[c] * sbq[c] + saq[c] * sbi[c];
      #1;
      checks++;
      if (out_i !== pi[2] || out_q !== pq[2]) begin
        failures++;
        $display("FAIL stream_model_c%0d: got (%0d,%0d) want (%0d,%0d)", c, out_i, out_q, pi[2], pq[2]);
      end
      if (c >= 2) begin
        checks++;
        if (out_i !== 64'(fi[c - 2]) || out_q !== 64'(fq[c - 2])) begin
          failures++;
          $display("FAIL stream_order_c%0d: got (%0d,%0d) want (%0d,%0d)", c, out_i, out_q, fi[c - 2], fq[c - 2]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_extremes();
    test_random();
    test_reset_release();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
